// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/MEM arbiter sequencing 32-bit words as four big-endian byte beats
module unified_mem_arbiter #(
   parameter int ADDRESSWIDTH = 32,
   parameter int DATA         = 32,
   parameter int MEMDEPTH     = 4096,
   parameter int MEMWIDTH     = 8,
   parameter int BYTESPERWORD = DATA / MEMWIDTH
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        if_req,
   input  logic [ADDRESSWIDTH-1:0]     if_addr,
   output logic                        if_done,
   output logic [DATA-1:0]             if_rdata,
   input  logic                        d_req,
   input  logic                        d_we,
   input  logic [ADDRESSWIDTH-1:0]     d_addr,
   input  logic [DATA-1:0]             d_wdata,
   output logic                        d_done,
   output logic [DATA-1:0]             d_rdata,
   output logic                        d_err,
   output logic                        if_err,
   output logic [$clog2(MEMDEPTH)-1:0] mem_addr,
   output logic                        mem_we,
   output logic [MEMWIDTH-1:0]         mem_wdata,
   input  logic [MEMWIDTH-1:0]         mem_rdata,
   output logic                        busy
);

   localparam int IW = $clog2(MEMDEPTH);
   localparam int BW = $clog2(BYTESPERWORD);
   localparam int SW = DATA - MEMWIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t            state_q;
   logic [BW-1:0]     beat_q;
   logic              last_d_q;
   logic              own_d_q;
   logic              we_q;
   logic [IW-1:0]     idx_q;
   logic [SW-1:0]     wbuf_q;
   logic [SW-1:0]     rbuf_q;
   logic              if_done_q, d_done_q, if_err_q, d_err_q, mem_we_q;
   logic [DATA-1:0]   if_rdata_q, d_rdata_q;
   logic [IW-1:0]     mem_addr_q;
   logic [MEMWIDTH-1:0] mem_wdata_q;

   // Tie goes to whichever requester did not win last; last_d_q=0 after reset favours data.
   logic                    grant_d;
   logic [ADDRESSWIDTH-1:0] g_addr;
   logic                    g_store;
   logic                    misaligned;
   logic [BW-1:0]           beat_nxt;
   logic [DATA-1:0]         word;

   assign grant_d    = d_req & (~if_req | ~last_d_q);
   assign g_addr     = grant_d ? d_addr : if_addr;
   assign g_store    = grant_d & d_we;
   assign misaligned = |g_addr[BW-1:0];
   assign beat_nxt   = beat_q + 1'b1;
   assign word       = {rbuf_q, mem_rdata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         last_d_q    <= 1'b0;
         own_d_q     <= 1'b0;
         we_q        <= 1'b0;
         idx_q       <= '0;
         wbuf_q      <= '0;
         rbuf_q      <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         if_err_q    <= 1'b0;
         d_err_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         if_err_q    <= 1'b0;
         d_err_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (if_req || d_req) begin
                  own_d_q  <= grant_d;
                  last_d_q <= grant_d;
                  we_q     <= g_store;
                  idx_q    <= g_addr[IW-1:0];
                  wbuf_q   <= g_store ? d_wdata[SW-1:0] : '0;
                  rbuf_q   <= '0;
                  beat_q   <= '0;
                  if (misaligned) begin
                     state_q  <= S_DONE;
                     d_done_q <= grant_d;
                     d_err_q  <= grant_d;
                     if_done_q <= ~grant_d;
                     if_err_q  <= ~grant_d;
                  end else begin
                     // Outputs are registered, so beat 0 is presented in the first ACCESS cycle.
                     state_q     <= S_ACCESS;
                     mem_addr_q  <= g_addr[IW-1:0];
                     mem_we_q    <= g_store;
                     mem_wdata_q <= g_store ? d_wdata[DATA-1 -: MEMWIDTH] : '0;
                  end
               end
            end
            S_ACCESS: begin
               rbuf_q <= {rbuf_q[SW-MEMWIDTH-1:0], mem_rdata};
               if (beat_q == BW'(BYTESPERWORD - 1)) begin
                  state_q <= S_DONE;
                  if (own_d_q) begin
                     d_done_q  <= 1'b1;
                     d_rdata_q <= we_q ? '0 : word;
                  end else begin
                     if_done_q  <= 1'b1;
                     if_rdata_q <= word;
                  end
               end else begin
                  beat_q      <= beat_nxt;
                  mem_addr_q  <= idx_q + IW'(beat_nxt);
                  mem_we_q    <= we_q;
                  mem_wdata_q <= we_q ? wbuf_q[SW-1 -: MEMWIDTH] : '0;
                  wbuf_q      <= {wbuf_q[SW-MEMWIDTH-1:0], {MEMWIDTH{1'b0}}};
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign if_done   = if_done_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign d_done    = d_done_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed vector bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        if_err;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mem [4096];
   logic       loaded = 1'b0;

   always #5 clk = ~clk;

   unified_mem_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err), .if_err(if_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
         mem[12'h100] <= 8'h8C; mem[12'h101] <= 8'h22; mem[12'h102] <= 8'h00; mem[12'h103] <= 8'h04;
         mem[12'h104] <= 8'h01; mem[12'h105] <= 8'h02; mem[12'h106] <= 8'h03; mem[12'h107] <= 8'h04;
         for (int i = 12'h300; i < 12'h304; i++) mem[i] <= 8'h55;
         loaded <= 1'b1;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [11:0] idx;
      logic [7:0]  exp_b;
      int          nb;
      idx = v.addr[11:0];
      @(negedge clk);
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      nb = v.exp_err ? 0 : 4;
      for (int k = 0; k < nb; k++) begin
         @(posedge clk); #1;
         exp_b = v.we ? v.wdata[31-8*k -: 8] : 8'h00;
         chk("beat", {busy, mem_we, mem_addr, mem_wdata}, {1'b1, v.we, idx + 12'(k), exp_b});
      end
      @(posedge clk); #1;
      chk("done", {if_done, if_err, d_done, d_err},
          v.is_d ? {2'b00, 1'b1, v.exp_err} : {1'b1, v.exp_err, 2'b00});
      chk("rdata", {if_rdata, d_rdata}, v.is_d ? {32'h0, v.exp_rdata} : {v.exp_rdata, 32'h0});
      chk("done_mem_idle", {mem_we, mem_addr, mem_wdata}, '0);
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
   endtask

   initial begin
      logic [1:0]  exp_done;
      logic [31:0] word;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h8C22_0004, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0203, 32'hCAFE_F00D, 32'h0,         1'b1};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         1'b1};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_1FFC, 32'h1122_3344, 32'h0,         1'b0};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'h1122_3344, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 32'hABC0_0200, 32'h0,         32'hDEAD_BEEF, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {if_done, if_rdata, if_err, d_done, d_rdata, d_err, mem_addr, mem_we, mem_wdata, busy}, '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_no_req", {busy, if_done, d_done, mem_we}, '0);

      // Contention straight after reset: data wins first, then grants alternate.
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
      for (int n = 1; n <= 23; n++) begin
         @(posedge clk); #1;
         exp_done = (n == 5 || n == 17) ? 2'b01 : (n == 11 || n == 23) ? 2'b10 : 2'b00;
         chk("contention_done", {if_done, d_done}, exp_done);
         if (exp_done == 2'b01) chk("contention_d_rdata", d_rdata, 32'h0102_0304);
         if (exp_done == 2'b10) chk("contention_if_rdata", if_rdata, 32'h8C22_0004);
      end
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      chk("contention_back_idle", busy, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
         if (i == 3) begin
            word = {mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h203]};
            chk("misaligned_mem_unchanged", word, 32'hDEAD_BEEF);
         end
      end
      word = {mem[12'hFFC], mem[12'hFFD], mem[12'hFFE], mem[12'hFFF]};
      chk("wrap_mem_contents", word, 32'h1122_3344);

      // Reset during beat 2 of a store: beats 0 and 1 land, the rest never do.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hA1B2_C3D4;
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      d_req = 1'b0; d_we = 1'b0;
      #1;
      chk("midreset_outputs", {if_done, if_rdata, if_err, d_done, d_rdata, d_err, mem_addr, mem_we, mem_wdata, busy}, '0);
      repeat (2) @(posedge clk);
      #1;
      word = {mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]};
      chk("midreset_partial_write", word, 32'hA1B2_5555);
      @(negedge clk);
      reset_n = 1'b1;
      run_vec('{1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hA1B2_5555, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
